// File: rtl/mem_stage_pkg.sv
// Shared pipeline constants for the MEM stage.
//   WIDTH_*        : access-size codes carried on ctl_width.
//   is_misaligned  : alignment rule for a given width and byte offset.
package mem_stage_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b11;

  // Code 2'b10 is unused by the decoder and is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] width,
                                         input logic [1:0] offset);
    case (width)
      WIDTH_BYTE: is_misaligned = 1'b0;
      WIDTH_HALF: is_misaligned = offset[0];
      default:    is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// Data memory for the MEM stage: word-addressed storage with per-byte-lane
// write enables, an asynchronous pipeline read port and an asynchronous
// debug read port. Four byte lanes per word (datapath is 32 bits wide).
//   i_clk, i_reset    : clock, synchronous active-high reset (clears all words)
//   i_byte_en         : per-lane write enable, lane 0 = bits [7:0]
//   i_addr            : word index used for both write and pipeline read
//   i_wdata           : write data, already positioned in its lanes
//   o_rdata           : word at i_addr
//   i_debug_addr      : debug word index
//   o_debug_data      : word at i_debug_addr
module data_memory #(
  parameter int BITS_SIZE     = 32,
  parameter int BITS_ADDR_MEM = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [3:0]               i_byte_en,
  input  logic [BITS_ADDR_MEM-1:0] i_addr,
  input  logic [BITS_SIZE-1:0]     i_wdata,
  output logic [BITS_SIZE-1:0]     o_rdata,
  input  logic [BITS_ADDR_MEM-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0]     o_debug_data
);

  localparam int DEPTH = 1 << BITS_ADDR_MEM;

  logic [BITS_SIZE-1:0] mem [DEPTH];

  // NOTE: the whole array is cleared on reset, so it maps to flops rather
  // than a RAM macro; keep DEPTH small if this block is reused.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (i_byte_en[b]) mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  assign o_rdata      = mem[i_addr];
  assign o_debug_data = mem[i_debug_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM latch, alignment check, store lane steering
// and load extraction/extension around a data_memory instance.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_step              : advance enable; latch and memory writes gated by it
//   i_alu_result        : byte address from EX
//   i_data_register_B   : store data from EX
//   i_mux_register_rd   : destination register from EX
//   i_ctl_*             : control bits from EX (width, unsigned, read/write...)
//   i_debug_addr        : debug word-read address
//   o_exmem_*           : latched EX/MEM fields for forwarding / writeback
//   o_halt              : latched halt
//   o_mem_read_data     : formatted load data (0 when not loading/misaligned)
//   o_misaligned        : latched access violates alignment
//   o_debug_mem_data    : memory word at i_debug_addr
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BITS_SIZE     = 32,
  parameter int BITS_REGS     = 5,
  parameter int BITS_ADDR_MEM = 5
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_step,
  input  logic [BITS_SIZE-1:0]     i_alu_result,
  input  logic [BITS_SIZE-1:0]     i_data_register_B,
  input  logic [BITS_REGS-1:0]     i_mux_register_rd,
  input  logic                     i_ctl_mem_read,
  input  logic                     i_ctl_mem_write,
  input  logic                     i_ctl_reg_write,
  input  logic                     i_ctl_mem_to_reg,
  input  logic                     i_ctl_halt,
  input  logic [1:0]               i_ctl_width,
  input  logic                     i_ctl_unsigned,
  input  logic [BITS_ADDR_MEM-1:0] i_debug_addr,
  output logic [BITS_SIZE-1:0]     o_exmem_register,
  output logic [BITS_REGS-1:0]     o_exmem_rd,
  output logic                     o_exmem_reg_write,
  output logic                     o_exmem_mem_to_reg,
  output logic                     o_halt,
  output logic [BITS_SIZE-1:0]     o_mem_read_data,
  output logic                     o_misaligned,
  output logic [BITS_SIZE-1:0]     o_debug_mem_data
);

  // EX/MEM latch
  logic [BITS_SIZE-1:0] ex_addr;
  logic [BITS_SIZE-1:0] ex_data;
  logic [BITS_REGS-1:0] ex_rd;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic                 ex_reg_write;
  logic                 ex_mem_to_reg;
  logic                 ex_halt;
  logic [1:0]           ex_width;
  logic                 ex_unsigned;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex_addr       <= '0;
      ex_data       <= '0;
      ex_rd         <= '0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_halt       <= 1'b0;
      ex_width      <= WIDTH_BYTE;
      ex_unsigned   <= 1'b0;
    end else if (i_step) begin
      ex_addr       <= i_alu_result;
      ex_data       <= i_data_register_B;
      ex_rd         <= i_mux_register_rd;
      ex_mem_read   <= i_ctl_mem_read;
      ex_mem_write  <= i_ctl_mem_write;
      ex_reg_write  <= i_ctl_reg_write;
      ex_mem_to_reg <= i_ctl_mem_to_reg;
      ex_halt       <= i_ctl_halt;
      ex_width      <= i_ctl_width;
      ex_unsigned   <= i_ctl_unsigned;
    end
  end

  // Upper address bits are dropped, so out-of-range addresses wrap.
  logic [BITS_ADDR_MEM-1:0] word_idx;
  logic [1:0]               offset;
  logic                     misaligned_raw;

  assign word_idx       = ex_addr[BITS_ADDR_MEM+1:2];
  assign offset         = ex_addr[1:0];
  assign misaligned_raw = is_misaligned(ex_width, offset);

  // Store steering: data replicated across lanes, mask picks the target.
  logic [3:0]           lane_mask;
  logic [BITS_SIZE-1:0] wdata;
  logic [3:0]           byte_en;

  // NOTE: defaults first so every path assigns every output; no latches.
  always_comb begin
    lane_mask = 4'b0000;
    wdata     = ex_data;
    case (ex_width)
      WIDTH_BYTE: begin
        lane_mask = 4'b0001 << offset;
        wdata     = BITS_SIZE'({4{ex_data[7:0]}});
      end
      WIDTH_HALF: begin
        lane_mask = offset[1] ? 4'b1100 : 4'b0011;
        wdata     = BITS_SIZE'({2{ex_data[15:0]}});
      end
      default: lane_mask = 4'b1111;
    endcase
  end

  // Reset precedence over a pending store is handled inside data_memory.
  assign byte_en = (i_step && ex_mem_write && !misaligned_raw) ? lane_mask : 4'b0000;

  logic [BITS_SIZE-1:0] rd_word;

  data_memory #(
    .BITS_SIZE    (BITS_SIZE),
    .BITS_ADDR_MEM(BITS_ADDR_MEM)
  ) u_data_memory (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_byte_en   (byte_en),
    .i_addr      (word_idx),
    .i_wdata     (wdata),
    .o_rdata     (rd_word),
    .i_debug_addr(i_debug_addr),
    .o_debug_data(o_debug_mem_data)
  );

  // Load formatting (little-endian lanes).
  logic [7:0]           byte_val;
  logic [15:0]          half_val;
  logic [BITS_SIZE-1:0] load_val;

  assign byte_val = rd_word[{offset, 3'b000} +: 8];
  assign half_val = rd_word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    case (ex_width)
      WIDTH_BYTE: load_val = {{(BITS_SIZE-8){byte_val[7] & ~ex_unsigned}}, byte_val};
      WIDTH_HALF: load_val = {{(BITS_SIZE-16){half_val[15] & ~ex_unsigned}}, half_val};
      default:    load_val = rd_word;
    endcase
  end

  assign o_mem_read_data    = (ex_mem_read && !misaligned_raw) ? load_val : '0;
  assign o_misaligned       = misaligned_raw && (ex_mem_read || ex_mem_write);
  assign o_exmem_register   = ex_addr;
  assign o_exmem_rd         = ex_rd;
  assign o_exmem_reg_write  = ex_reg_write;
  assign o_exmem_mem_to_reg = ex_mem_to_reg;
  assign o_halt             = ex_halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        i_clk;
  logic        i_reset;
  logic        i_step;
  logic [31:0] i_alu_result;
  logic [31:0] i_data_register_B;
  logic [4:0]  i_mux_register_rd;
  logic        i_ctl_mem_read;
  logic        i_ctl_mem_write;
  logic        i_ctl_reg_write;
  logic        i_ctl_mem_to_reg;
  logic        i_ctl_halt;
  logic [1:0]  i_ctl_width;
  logic        i_ctl_unsigned;
  logic [4:0]  i_debug_addr;
  logic [31:0] o_exmem_register;
  logic [4:0]  o_exmem_rd;
  logic        o_exmem_reg_write;
  logic        o_exmem_mem_to_reg;
  logic        o_halt;
  logic [31:0] o_mem_read_data;
  logic        o_misaligned;
  logic [31:0] o_debug_mem_data;

  int checks   = 0;
  int failures = 0;

  mem_stage #(
    .BITS_SIZE    (32),
    .BITS_REGS    (5),
    .BITS_ADDR_MEM(5)
  ) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_step            (i_step),
    .i_alu_result      (i_alu_result),
    .i_data_register_B (i_data_register_B),
    .i_mux_register_rd (i_mux_register_rd),
    .i_ctl_mem_read    (i_ctl_mem_read),
    .i_ctl_mem_write   (i_ctl_mem_write),
    .i_ctl_reg_write   (i_ctl_reg_write),
    .i_ctl_mem_to_reg  (i_ctl_mem_to_reg),
    .i_ctl_halt        (i_ctl_halt),
    .i_ctl_width       (i_ctl_width),
    .i_ctl_unsigned    (i_ctl_unsigned),
    .i_debug_addr      (i_debug_addr),
    .o_exmem_register  (o_exmem_register),
    .o_exmem_rd        (o_exmem_rd),
    .o_exmem_reg_write (o_exmem_reg_write),
    .o_exmem_mem_to_reg(o_exmem_mem_to_reg),
    .o_halt            (o_halt),
    .o_mem_read_data   (o_mem_read_data),
    .o_misaligned      (o_misaligned),
    .o_debug_mem_data  (o_debug_mem_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic [1:0] w,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
    i_step            = 1'b1;
    i_ctl_mem_read    = mr;
    i_ctl_mem_write   = mw;
    i_ctl_width       = w;
    i_ctl_unsigned    = u;
    i_alu_result      = a;
    i_data_register_B = d;
    i_mux_register_rd = 5'd0;
    i_ctl_reg_write   = 1'b0;
    i_ctl_mem_to_reg  = 1'b0;
    i_ctl_halt        = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, WIDTH_WORD, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, WIDTH_HALF, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    i_mux_register_rd = 5'h1F;
    i_ctl_reg_write   = 1'b1;
    i_ctl_mem_to_reg  = 1'b1;
    i_ctl_halt        = 1'b1;
    i_reset           = 1'b1;
    i_debug_addr      = 5'd7;
    tick();
    checks++;
    if ({o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt,
         o_mem_read_data, o_misaligned, o_debug_mem_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: reg=%h rd=%h rw=%b m2r=%b halt=%b data=%h mis=%b dbg=%h, all required 0",
               o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt,
               o_mem_read_data, o_misaligned, o_debug_mem_data);
    end
    i_reset = 1'b0;
    idle();
  endtask

  task automatic test_controls();
    drive(1'b0, 1'b0, WIDTH_WORD, 1'b0, 32'h0000_1234, 32'h0);
    i_mux_register_rd = 5'h15;
    i_ctl_reg_write   = 1'b1;
    i_ctl_mem_to_reg  = 1'b1;
    i_ctl_halt        = 1'b1;
    tick();
    checks++;
    if ({o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt}
        !== {32'h0000_1234, 5'h15, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL ctl_latch: reg=%h rd=%h rw=%b m2r=%b halt=%b, required 00001234 15 1 1 1",
               o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt);
    end
    idle();
    tick();
    checks++;
    if ({o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt} !== '0) begin
      failures++;
      $display("FAIL ctl_clear: rd=%h rw=%b m2r=%b halt=%b, required 0",
               o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt);
    end
  endtask

  task automatic test_word();
    drive(1'b0, 1'b1, WIDTH_WORD, 1'b0, 32'h8, 32'hDEAD_BEEF);
    tick();
    checks++;
    if (o_exmem_register !== 32'h8 || o_mem_read_data !== 32'h0 || o_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL word_store_latch: reg=%h data=%h mis=%b, required 00000008 00000000 0",
               o_exmem_register, o_mem_read_data, o_misaligned);
    end
    drive(1'b1, 1'b0, WIDTH_WORD, 1'b0, 32'h8, 32'h0);
    i_debug_addr = 5'd2;
    tick();
    checks++;
    if (o_mem_read_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL word_load: got %h, required deadbeef", o_mem_read_data);
    end
    checks++;
    if (o_debug_mem_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL word_debug: got %h, required deadbeef", o_debug_mem_data);
    end
  endtask

  task automatic test_byte();
    drive(1'b0, 1'b1, WIDTH_BYTE, 1'b0, 32'h5, 32'hAAAA_AA80);
    tick();
    drive(1'b1, 1'b0, WIDTH_BYTE, 1'b0, 32'h5, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'hFFFF_FF80) begin
      failures++;
      $display("FAIL byte_load_signed: got %h, required ffffff80", o_mem_read_data);
    end
    drive(1'b1, 1'b0, WIDTH_BYTE, 1'b1, 32'h5, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h0000_0080) begin
      failures++;
      $display("FAIL byte_load_unsigned: got %h, required 00000080", o_mem_read_data);
    end
    i_debug_addr = 5'd1;
    #1;
    checks++;
    if (o_debug_mem_data !== 32'h0000_8000) begin
      failures++;
      $display("FAIL byte_debug: got %h, required 00008000", o_debug_mem_data);
    end
    // Lanes 0 and 3 of word 2 (0xDEADBEEF).
    drive(1'b1, 1'b0, WIDTH_BYTE, 1'b0, 32'h8, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'hFFFF_FFEF) begin
      failures++;
      $display("FAIL byte_lane0: got %h, required ffffffef", o_mem_read_data);
    end
    drive(1'b1, 1'b0, WIDTH_BYTE, 1'b1, 32'hB, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h0000_00DE) begin
      failures++;
      $display("FAIL byte_lane3: got %h, required 000000de", o_mem_read_data);
    end
  endtask

  task automatic test_half();
    // Copy word 2 into word 0 first: word store 0xDEADBEEF at addr 0.
    drive(1'b0, 1'b1, WIDTH_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b1, WIDTH_HALF, 1'b0, 32'h2, 32'hFFFF_1234);
    tick();
    drive(1'b1, 1'b0, WIDTH_HALF, 1'b0, 32'h3, 32'h0);
    tick();
    i_debug_addr = 5'd0;
    #1;
    checks++;
    if (o_misaligned !== 1'b1 || o_mem_read_data !== 32'h0) begin
      failures++;
      $display("FAIL half_misaligned_load: mis=%b data=%h, required 1 00000000",
               o_misaligned, o_mem_read_data);
    end
    checks++;
    if (o_debug_mem_data !== 32'h1234_BEEF) begin
      failures++;
      $display("FAIL half_store_mem: got %h, required 1234beef", o_debug_mem_data);
    end
    drive(1'b0, 1'b1, WIDTH_HALF, 1'b0, 32'h1, 32'h0000_5555);
    tick();
    checks++;
    if (o_misaligned !== 1'b1) begin
      failures++;
      $display("FAIL half_misaligned_store_flag: got %b, required 1", o_misaligned);
    end
    drive(1'b1, 1'b0, WIDTH_HALF, 1'b0, 32'h2, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h0000_1234 || o_debug_mem_data !== 32'h1234_BEEF) begin
      failures++;
      $display("FAIL half_load_aligned: data=%h mem=%h, required 00001234 1234beef",
               o_mem_read_data, o_debug_mem_data);
    end
    drive(1'b1, 1'b0, WIDTH_HALF, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'hFFFF_BEEF) begin
      failures++;
      $display("FAIL half_load_signed: got %h, required ffffbeef", o_mem_read_data);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h1234_BEEF || o_misaligned !== 1'b0) begin
      failures++;
      $display("FAIL width10_word: data=%h mis=%b, required 1234beef 0",
               o_mem_read_data, o_misaligned);
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h0 || o_misaligned !== 1'b1) begin
      failures++;
      $display("FAIL width10_misaligned: data=%h mis=%b, required 00000000 1",
               o_mem_read_data, o_misaligned);
    end
    idle();
    tick();
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, WIDTH_WORD, 1'b0, 32'hC, 32'hCAFE_F00D);
    tick();
    drive(1'b1, 1'b0, WIDTH_BYTE, 1'b1, 32'h0, 32'h5555_5555);
    i_mux_register_rd = 5'h09;
    i_ctl_reg_write   = 1'b1;
    i_step            = 1'b0;
    i_debug_addr      = 5'd3;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (o_exmem_register !== 32'hC || o_exmem_rd !== 5'h0 || o_exmem_reg_write !== 1'b0 ||
          o_mem_read_data !== 32'h0 || o_debug_mem_data !== 32'h0) begin
        failures++;
        $display("FAIL hold_cycle%0d: reg=%h rd=%h rw=%b data=%h mem3=%h, required 0000000c 00 0 00000000 00000000",
                 c, o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_mem_read_data, o_debug_mem_data);
      end
    end
    drive(1'b1, 1'b0, WIDTH_WORD, 1'b0, 32'hC, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'hCAFE_F00D || o_debug_mem_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL hold_release: data=%h mem3=%h, required cafef00d cafef00d",
               o_mem_read_data, o_debug_mem_data);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, WIDTH_BYTE, 1'b0, 32'h84, 32'h0000_0011);
    tick();
    checks++;
    if (o_exmem_register !== 32'h84) begin
      failures++;
      $display("FAIL wrap_latch: got %h, required 00000084", o_exmem_register);
    end
    idle();
    tick();
    i_debug_addr = 5'd1;
    #1;
    checks++;
    if (o_debug_mem_data !== 32'h0000_8011) begin
      failures++;
      $display("FAIL wrap_write: got %h, required 00008011", o_debug_mem_data);
    end
  endtask

  task automatic test_reset_inflight();
    int nonzero;
    drive(1'b0, 1'b1, WIDTH_WORD, 1'b0, 32'h10, 32'h1234_5678);
    tick();
    i_reset = 1'b1;
    tick();
    checks++;
    if ({o_exmem_register, o_exmem_rd, o_exmem_reg_write, o_exmem_mem_to_reg, o_halt,
         o_mem_read_data, o_misaligned} !== '0) begin
      failures++;
      $display("FAIL inflight_outputs: reg=%h rd=%h data=%h mis=%b, required all 0",
               o_exmem_register, o_exmem_rd, o_mem_read_data, o_misaligned);
    end
    nonzero = 0;
    for (int w = 0; w < 32; w++) begin
      i_debug_addr = w[4:0];
      #1;
      if (o_debug_mem_data !== 32'h0) nonzero++;
    end
    checks++;
    if (nonzero !== 0) begin
      failures++;
      $display("FAIL inflight_mem_clear: %0d nonzero words, required 0", nonzero);
    end
    i_reset = 1'b0;
    drive(1'b1, 1'b0, WIDTH_WORD, 1'b0, 32'h10, 32'h0);
    tick();
    checks++;
    if (o_mem_read_data !== 32'h0) begin
      failures++;
      $display("FAIL inflight_dropped: got %h, required 00000000", o_mem_read_data);
    end
  endtask

  initial begin
    i_reset      = 1'b0;
    i_debug_addr = 5'd0;
    idle();
    test_reset();
    test_controls();
    test_word();
    test_byte();
    test_half();
    test_hold();
    test_wrap();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
